// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_round
// Description : Back end of the FP32 multiply path. Captures the 48-bit
//               mantissa product from the shift-add multiplier, normalizes it,
//               rounds to nearest-even, adjusts the exponent, detects
//               overflow/underflow and packs an IEEE-754 single result.
//               Denormal results are flushed to signed zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_round #(
  parameter int MANT_W = 24,  // mantissa width including hidden bit
  parameter int EXP_W  = 10,  // signed width of the incoming biased exponent sum
  parameter int OEXP_W = 8    // packed exponent width
) (
  input  logic                        clk,
  input  logic                        reset,      // asynchronous, active-low
  input  logic                        in_en,
  input  logic [2*MANT_W-1:0]         p,
  input  logic                        sign_in,
  input  logic signed [EXP_W-1:0]     exp_in,
  input  logic                        zero_in,
  output logic [OEXP_W+MANT_W-1:0]    result,
  output logic                        done,
  output logic                        busy,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW  = 2 * MANT_W;       // product width
  localparam int RW  = OEXP_W + MANT_W;  // packed result width (sign + exp + fraction)
  localparam int FW  = MANT_W - 1;       // stored fraction width
  // Two guard bits on the exponent: normalization and round carry can each add
  // one, and the saturation/flush tests must see the true signed value.
  localparam int IEW = EXP_W + 2;

  localparam logic signed [IEW-1:0] C_EXP_ONE  = IEW'(1);
  localparam logic signed [IEW-1:0] C_EXP_ZERO = '0;
  localparam logic signed [IEW-1:0] C_EXP_MAX  = IEW'((1 << OEXP_W) - 1);
  localparam logic [MANT_W-1:0]     C_M_CARRY  = {1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_PACK  = 2'd3
  } state_t;

  state_t                 state_q,  state_d;
  logic [PW-1:0]          p_q,      p_d;
  logic                   sign_q,   sign_d;
  logic                   zero_q,   zero_d;
  logic signed [IEW-1:0]  e_q,      e_d;
  logic [MANT_W-1:0]      m_q,      m_d;
  logic                   g_q,      g_d;      // guard bit (first bit below the lsb)
  logic                   s_q,      s_d;      // sticky: OR of everything below guard
  logic [RW-1:0]          result_q, result_d;
  logic                   done_q,   done_d;
  logic                   busy_q,   busy_d;
  logic                   ovf_q,    ovf_d;
  logic                   unf_q,    unf_d;

  // Mantissa increment with carry-out; the carry marks the all-ones case.
  logic [MANT_W:0]        w_m_inc;
  assign w_m_inc = {1'b0, m_q} + {{MANT_W{1'b0}}, 1'b1};

  // Next-state and datapath for the four-step normalize/round/pack sequence.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    e_d      = e_q;
    m_d      = m_q;
    g_d      = g_q;
    s_d      = s_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      S_IDLE: begin
        // Captures are accepted only here, including the cycle done is high.
        if (in_en) begin
          p_d     = p;
          sign_d  = sign_in;
          zero_d  = zero_in;
          e_d     = {{2{exp_in[EXP_W-1]}}, exp_in};
          busy_d  = 1'b1;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // The product of two normalized mantissas lies in [1,4): the leading
        // one is at bit PW-1 or PW-2. A top-bit product gains one exponent.
        if (p_q[PW-1]) begin
          m_d = p_q[PW-1 -: MANT_W];
          g_d = p_q[MANT_W-1];
          s_d = |p_q[MANT_W-2:0];
          e_d = e_q + C_EXP_ONE;
        end else begin
          m_d = p_q[PW-2 -: MANT_W];
          g_d = p_q[MANT_W-2];
          s_d = |p_q[MANT_W-3:0];
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        // Round to nearest, ties to even: bump when above half, or exactly
        // half with an odd lsb. An all-ones mantissa carries into 1.000..0.
        if (g_q && (s_q || m_q[0])) begin
          if (w_m_inc[MANT_W]) begin
            m_d = C_M_CARRY;
            e_d = e_q + C_EXP_ONE;
          end else begin
            m_d = w_m_inc[MANT_W-1:0];
          end
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        // Zero operands win over any exponent condition; then saturation,
        // then flush-to-zero (no denormals are produced).
        if (zero_q) begin
          result_d = {sign_q, {(RW-1){1'b0}}};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (e_q >= C_EXP_MAX) begin
          result_d = {sign_q, {OEXP_W{1'b1}}, {FW{1'b0}}};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else if (e_q <= C_EXP_ZERO) begin
          result_d = {sign_q, {(RW-1){1'b0}}};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_q[OEXP_W-1:0], m_q[FW-1:0]};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      g_q      <= 1'b0;
      s_q      <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      e_q      <= e_d;
      m_q      <= m_d;
      g_q      <= g_d;
      s_q      <= s_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_round
// Description : Scoreboard bench for fp_normalize_round: directed IEEE cases,
//               random products, busy-time captures, reset abort and
//               back-to-back operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_round;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_en;
  logic [47:0]        p;
  logic               sign_in;
  logic signed [9:0]  exp_in;
  logic               zero_in;
  logic [31:0]        result;
  logic               done;
  logic               busy;
  logic               overflow;
  logic               underflow;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_normalize_round #(.MANT_W(24), .EXP_W(10), .OEXP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .p         (p),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .zero_in   (zero_in),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Reference: shift the product down to 24 bits and round on the remainder.
  function automatic exp_t model(input logic [47:0] pv, input logic s,
                                 input int e_in, input logic z);
    exp_t        r;
    int          e;
    int          sh;
    logic [47:0] mant;
    logic [47:0] rem;
    logic [47:0] half;
    e  = e_in;
    sh = pv[47] ? 24 : 23;
    if (pv[47]) e = e + 1;
    mant = pv >> sh;
    rem  = pv & ((48'd1 << sh) - 48'd1);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + 48'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    r = '0;
    if (z) begin
      r.res = {s, 31'b0};
    end else if (e >= 255) begin
      r.res = {s, 8'hFF, 23'b0};
      r.ov  = 1'b1;
    end else if (e <= 0) begin
      r.res = {s, 31'b0};
      r.un  = 1'b1;
    end else begin
      r.res = {s, e[7:0], mant[22:0]};
    end
    return r;
  endfunction

  // Drive one in_en pulse at the current negedge and push its expectation.
  task automatic launch(input logic [47:0] pv, input logic s,
                        input logic signed [9:0] e, input logic z);
    in_en   = 1'b1;
    p       = pv;
    sign_in = s;
    exp_in  = e;
    zero_in = z;
    sb.push_back(model(pv, s, int'(e), z));
    @(negedge clk);
    in_en = 1'b0;
  endtask

  // Count negedges until done (bounded); -1 means it never came.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_en = 1'b0; p = '0; sign_in = 1'b0; exp_in = '0; zero_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", result, 32'h0); end
    n_checks++;
    if ({done, busy, overflow, underflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", {done, busy, overflow, underflow}, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Run one operation end to end and score it against the queue.
  task automatic run_one(input string name, input logic [47:0] pv, input logic s,
                         input logic signed [9:0] e, input logic z);
    int   cyc;
    exp_t ex;
    @(negedge clk);
    launch(pv, s, e, z);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
    wait_done(cyc);
    n_checks++;
    if (cyc != 3) begin n_fail++; $display("FAIL %s_latency: got %0d expected 3", name, cyc); end
    ex = sb.pop_front();
    n_checks++;
    if ({result, overflow, underflow, busy} !== {ex.res, ex.ov, ex.un, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_result: got %h ov=%b un=%b busy=%b expected %h ov=%b un=%b busy=0",
               name, result, overflow, underflow, busy, ex.res, ex.ov, ex.un);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== ex.res) begin
      n_fail++; $display("FAIL %s_hold: got done=%b %h expected done=0 %h", name, done, result, ex.res);
    end
  endtask

  task automatic test_directed();
    // Expectations for these come from the model; the fixed values are also
    // cross-checked against literal constants below.
    run_one("one",       48'h400000000000, 1'b0, 10'sd127, 1'b0);
    n_checks++;
    if (result !== 32'h3F800000) begin n_fail++; $display("FAIL one_const: got %h expected 3f800000", result); end
    run_one("one_5",     48'h900000000000, 1'b0, 10'sd127, 1'b0);
    n_checks++;
    if (result !== 32'h40100000) begin n_fail++; $display("FAIL one_5_const: got %h expected 40100000", result); end
    run_one("tie_odd",   48'h400000C00000, 1'b0, 10'sd127, 1'b0);
    n_checks++;
    if (result !== 32'h3F800002) begin n_fail++; $display("FAIL tie_odd_const: got %h expected 3f800002", result); end
    run_one("tie_even",  48'h400000400000, 1'b0, 10'sd127, 1'b0);
    n_checks++;
    if (result !== 32'h3F800000) begin n_fail++; $display("FAIL tie_even_const: got %h expected 3f800000", result); end
    run_one("carry",     48'hFFFFFFFFFFFF, 1'b0, 10'sd127, 1'b0);
    n_checks++;
    if (result !== 32'h40800000) begin n_fail++; $display("FAIL carry_const: got %h expected 40800000", result); end
    run_one("ovf",       48'h800000000000, 1'b0, 10'sd254, 1'b0);
    n_checks++;
    if ({result, overflow} !== {32'h7F800000, 1'b1}) begin
      n_fail++; $display("FAIL ovf_const: got %h ov=%b expected 7f800000 ov=1", result, overflow);
    end
    run_one("zero_op",   48'h900000000000, 1'b1, 10'sd300, 1'b1);
    run_one("unf",       48'h400000000000, 1'b1, 10'sd0,   1'b0);
    n_checks++;
    if ({result, underflow} !== {32'h80000000, 1'b1}) begin
      n_fail++; $display("FAIL unf_const: got %h un=%b expected 80000000 un=1", result, underflow);
    end
    run_one("neg_exp",   48'h600000000000, 1'b0, -10'sd5,  1'b0);
  endtask

  task automatic test_random();
    logic [47:0]       pv;
    logic signed [9:0] e;
    for (int i = 0; i < 24; i++) begin
      pv[47:32] = 16'($urandom_range(0, 65535));
      pv[31:0]  = $urandom;
      if (!pv[47]) pv[46] = 1'b1;
      if (i % 4 == 0) pv[23:0] = (i % 8 == 0) ? 24'h800000 : 24'h400000;
      e = 10'(int'($urandom_range(0, 320)) - 20);
      run_one("rand", pv, 1'($urandom_range(0, 1)), e, ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_busy_ignore();
    int   dones = 0;
    exp_t ex;
    logic [31:0] seen = '0;
    @(negedge clk);
    launch(48'h400000000000, 1'b0, 10'sd127, 1'b0);
    @(negedge clk);
    in_en = 1'b1; p = 48'hFFFFFFFFFFFF; exp_in = 10'sd200; sign_in = 1'b1; zero_in = 1'b0;
    @(negedge clk);
    in_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin dones++; seen = result; end
      @(negedge clk);
    end
    ex = sb.pop_front();
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL busy_ignore_count: got %0d expected 1", dones); end
    n_checks++;
    if (seen !== ex.res) begin n_fail++; $display("FAIL busy_ignore_result: got %h expected %h", seen, ex.res); end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int cyc;
    exp_t ex;
    run_one("pre_abort", 48'h900000000000, 1'b0, 10'sd127, 1'b0);
    @(negedge clk);
    launch(48'hFFFFFFFFFFFF, 1'b1, 10'sd254, 1'b0);
    @(negedge clk);  // now in ROUND
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    n_checks++;
    if ({result, done, busy, overflow, underflow} !== 36'h0) begin
      n_fail++; $display("FAIL abort_outputs: got %h %b%b%b%b expected all zero",
                         result, done, busy, overflow, underflow);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    @(negedge clk);
    launch(48'h400000000000, 1'b0, 10'sd128, 1'b0);
    wait_done(cyc);
    ex = sb.pop_front();
    n_checks++;
    if (cyc != 3 || result !== ex.res) begin
      n_fail++; $display("FAIL after_abort: got cyc=%0d %h expected cyc=3 %h", cyc, result, ex.res);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    exp_t ea;
    exp_t eb;
    @(negedge clk);
    launch(48'h900000000000, 1'b1, 10'sd100, 1'b0);
    wait_done(cyc);
    ea = sb.pop_front();
    n_checks++;
    if (cyc != 3 || result !== ea.res) begin
      n_fail++; $display("FAIL b2b_first: got cyc=%0d %h expected cyc=3 %h", cyc, result, ea.res);
    end
    // Capture in the cycle done is high.
    launch(48'h400000C00000, 1'b0, 10'sd1, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || result !== ea.res) begin
      n_fail++; $display("FAIL b2b_hold: got busy=%b %h expected busy=1 %h", busy, result, ea.res);
    end
    wait_done(cyc);
    eb = sb.pop_front();
    n_checks++;
    if (cyc != 3 || result !== eb.res || overflow !== eb.ov || underflow !== eb.un) begin
      n_fail++; $display("FAIL b2b_second: got cyc=%0d %h expected cyc=3 %h", cyc, result, eb.res);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
